// File: rtl/riscv_alu_iter.sv
// riscv_alu_iter: EX-stage integer ALU with single-cycle logic, add/sub,
// shift and lane-wise compare ops, plus an iterative restoring divider.
// Divide: DIVU/DIV/REMU/REM, one quotient bit per cycle, ready_o stalls EX.
// Ports: clk, rst_n (sync, active-low), enable_i, operator_i[6:0],
//   operand_a_i, operand_b_i, vector_mode_i[1:0] (10=16b lanes, 11=8b lanes),
//   result_o, comparison_result_o (MSB lane), ready_o, ex_ready_i.
// Optional macro RISCV_ALU_DIV_EARLY_TERM_EN: short-cut trivial divides and
//   skip the leading zeros of |A|.
`timescale 1ns/1ps
module riscv_alu_iter #(
    parameter int WIDTH = 32,
    parameter int LANES = WIDTH / 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic [6:0]       operator_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic [1:0]       vector_mode_i,
    output logic [WIDTH-1:0] result_o,
    output logic             comparison_result_o,
    output logic             ready_o,
    input  logic             ex_ready_i
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [6:0] ALU_ADD   = 7'b0011000;
    localparam logic [6:0] ALU_SUB   = 7'b0011001;
    localparam logic [6:0] ALU_XOR   = 7'b0101111;
    localparam logic [6:0] ALU_OR    = 7'b0101110;
    localparam logic [6:0] ALU_AND   = 7'b0010101;
    localparam logic [6:0] ALU_SRA   = 7'b0100100;
    localparam logic [6:0] ALU_SRL   = 7'b0100101;
    localparam logic [6:0] ALU_SLL   = 7'b0100111;
    localparam logic [6:0] ALU_LTS   = 7'b0000000;
    localparam logic [6:0] ALU_LTU   = 7'b0000001;
    localparam logic [6:0] ALU_SLTS  = 7'b0000010;
    localparam logic [6:0] ALU_SLTU  = 7'b0000011;
    localparam logic [6:0] ALU_LES   = 7'b0000100;
    localparam logic [6:0] ALU_LEU   = 7'b0000101;
    localparam logic [6:0] ALU_SLETS = 7'b0000110;
    localparam logic [6:0] ALU_SLETU = 7'b0000111;
    localparam logic [6:0] ALU_GTS   = 7'b0001000;
    localparam logic [6:0] ALU_GTU   = 7'b0001001;
    localparam logic [6:0] ALU_GES   = 7'b0001010;
    localparam logic [6:0] ALU_GEU   = 7'b0001011;
    localparam logic [6:0] ALU_EQ    = 7'b0001100;
    localparam logic [6:0] ALU_NE    = 7'b0001101;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] res_q;
    logic             is_rem_q;
    logic             neg_q_q;
    logic             neg_r_q;

    // ---------------- byte-lane compare network ----------------
    logic             signed_op;
    logic [LANES-1:0] lstart, ltop, gt_b, eq_b;
    logic [LANES-1:0] lane_gt, lane_eq, byte_gt, byte_eq, cmp_vec;
    logic             gt_acc, eq_acc, cur_gt, cur_eq, sa_b, sb_b;

    always_comb begin
        signed_op = operator_i inside {ALU_LTS, ALU_LES, ALU_GTS, ALU_GES,
                                       ALU_SLTS, ALU_SLETS};
        lstart  = '0;
        ltop    = '0;
        gt_b    = '0;
        eq_b    = '0;
        lane_gt = '0;
        lane_eq = '0;
        byte_gt = '0;
        byte_eq = '0;
        gt_acc  = 1'b0;
        eq_acc  = 1'b1;
        cur_gt  = 1'b0;
        cur_eq  = 1'b0;
        sa_b    = 1'b0;
        sb_b    = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            case (vector_mode_i)
                2'b11: begin
                    lstart[i] = 1'b1;
                    ltop[i]   = 1'b1;
                end
                2'b10: begin
                    lstart[i] = ~i[0];
                    ltop[i]   = i[0];
                end
                default: begin
                    lstart[i] = (i == 0);
                    ltop[i]   = (i == LANES - 1);
                end
            endcase
            // Only the top byte of a lane carries the sign.
            sa_b = signed_op & ltop[i] & operand_a_i[8*i+7];
            sb_b = signed_op & ltop[i] & operand_b_i[8*i+7];
            gt_b[i] = $signed({sa_b, operand_a_i[8*i +: 8]}) >
                      $signed({sb_b, operand_b_i[8*i +: 8]});
            eq_b[i] = operand_a_i[8*i +: 8] == operand_b_i[8*i +: 8];
            // Ripple from the lane's low byte; the top byte holds the verdict.
            if (lstart[i]) begin
                gt_acc = gt_b[i];
                eq_acc = eq_b[i];
            end else begin
                gt_acc = gt_b[i] | (eq_b[i] & gt_acc);
                eq_acc = eq_acc & eq_b[i];
            end
            lane_gt[i] = gt_acc;
            lane_eq[i] = eq_acc;
        end
        // Broadcast each lane verdict down to all bytes of the lane.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (ltop[i]) begin
                cur_gt = lane_gt[i];
                cur_eq = lane_eq[i];
            end
            byte_gt[i] = cur_gt;
            byte_eq[i] = cur_eq;
        end
    end

    always_comb begin
        unique case (operator_i)
            ALU_EQ:                                 cmp_vec = byte_eq;
            ALU_NE:                                 cmp_vec = ~byte_eq;
            ALU_GTS, ALU_GTU:                       cmp_vec = byte_gt;
            ALU_GES, ALU_GEU:                       cmp_vec = byte_gt | byte_eq;
            ALU_LTS, ALU_LTU, ALU_SLTS, ALU_SLTU:   cmp_vec = ~(byte_gt | byte_eq);
            ALU_LES, ALU_LEU, ALU_SLETS, ALU_SLETU: cmp_vec = ~byte_gt;
            default:                                cmp_vec = '0;
        endcase
    end

    assign comparison_result_o = cmp_vec[LANES-1];

    // ---------------- single-cycle result ----------------
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] cmp_wide;
    logic [WIDTH-1:0] alu_res;
    logic             is_div;
    logic             known_op;

    assign shamt  = operand_b_i[SH_W-1:0];
    assign is_div = operator_i[6:2] == 5'b01100;

    always_comb begin
        cmp_wide = '0;
        for (int i = 0; i < LANES; i++) begin
            cmp_wide[8*i +: 8] = {8{cmp_vec[i]}};
        end
        known_op = 1'b1;
        case (operator_i)
            ALU_ADD: alu_res = operand_a_i + operand_b_i;
            ALU_SUB: alu_res = operand_a_i - operand_b_i;
            ALU_AND: alu_res = operand_a_i & operand_b_i;
            ALU_OR:  alu_res = operand_a_i | operand_b_i;
            ALU_XOR: alu_res = operand_a_i ^ operand_b_i;
            ALU_SLL: alu_res = operand_a_i << shamt;
            ALU_SRL: alu_res = operand_a_i >> shamt;
            ALU_SRA: alu_res = WIDTH'($signed(operand_a_i) >>> shamt);
            ALU_EQ, ALU_NE, ALU_GTS, ALU_GTU, ALU_GES, ALU_GEU,
            ALU_LTS, ALU_LTU, ALU_LES, ALU_LEU:
                alu_res = cmp_wide;
            ALU_SLTS, ALU_SLTU, ALU_SLETS, ALU_SLETU:
                alu_res = {{(WIDTH-1){1'b0}}, cmp_vec[LANES-1]};
            default: begin
                alu_res  = '0;
                known_op = is_div;
            end
        endcase
    end

    // ---------------- divider datapath ----------------
    logic             div_signed, a_neg, b_neg, b_zero, r_ge;
    logic [WIDTH-1:0] abs_a, abs_b, r_diff, r_nx, q_nx, fin;
    logic [WIDTH:0]   r_sh;

    assign div_signed = operator_i[0];
    assign a_neg  = div_signed & operand_a_i[WIDTH-1];
    assign b_neg  = div_signed & operand_b_i[WIDTH-1];
    assign b_zero = operand_b_i == '0;
    assign abs_a  = a_neg ? -operand_a_i : operand_a_i;
    assign abs_b  = b_neg ? -operand_b_i : operand_b_i;

    // One restoring step; quotient bits shift into the dividend register.
    assign r_sh   = {rem, dvd[WIDTH-1]};
    assign r_ge   = r_sh >= {1'b0, dsr};
    assign r_diff = r_sh[WIDTH-1:0] - dsr;
    assign r_nx   = r_ge ? r_diff : r_sh[WIDTH-1:0];
    assign q_nx   = {dvd[WIDTH-2:0], r_ge};
    assign fin    = is_rem_q ? (neg_r_q ? -r_nx : r_nx)
                             : (neg_q_q ? -q_nx : q_nx);

`ifdef RISCV_ALU_DIV_EARLY_TERM_EN
    function automatic logic [CNT_W-1:0] clz(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] n;
        logic             hit;
        n   = '0;
        hit = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!hit && !v[i]) n = n + CNT_W'(1);
            else hit = 1'b1;
        end
        return n;
    endfunction

    logic [CNT_W-1:0] clz_a;
    logic             trivial;
    logic [WIDTH-1:0] early_res;

    assign clz_a     = clz(abs_a);
    assign trivial   = b_zero | (abs_a < abs_b);
    // Trivial case: quotient is 0 (or all ones for /0), remainder is A.
    assign early_res = operator_i[1] ? operand_a_i : {WIDTH{b_zero}};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dvd      <= '0;
            rem      <= '0;
            dsr      <= '0;
            res_q    <= '0;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i && is_div) begin
                        dsr      <= abs_b;
                        rem      <= '0;
                        is_rem_q <= operator_i[1];
                        // x/0 keeps an all-ones quotient regardless of sign.
                        neg_q_q  <= (a_neg ^ b_neg) & ~b_zero;
                        neg_r_q  <= a_neg;
`ifdef RISCV_ALU_DIV_EARLY_TERM_EN
                        if (trivial) begin
                            res_q <= early_res;
                            state <= DONE;
                        end else begin
                            cnt   <= CNT_W'(WIDTH) - clz_a;
                            dvd   <= abs_a << clz_a;
                            state <= RUN;
                        end
`else
                        cnt   <= CNT_W'(WIDTH);
                        dvd   <= abs_a;
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    dvd <= q_nx;
                    rem <= r_nx;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        res_q <= fin;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (ex_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_o  = (state == DONE) ||
                      ((state == IDLE) && !(enable_i && is_div));
    assign result_o = (state == IDLE) ? alu_res : res_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && state == IDLE && enable_i && !known_op)
            $warning("riscv_alu_iter: unsupported operator %b", operator_i);
    end
`endif

endmodule

// File: tb/tb_riscv_alu_iter.sv
// Testbench for riscv_alu_iter: table vectors, randomized single-cycle ops
// and divides against a behavioural model, plus stall/reset sequences.
`timescale 1ns/1ps
module tb_riscv_alu_iter;
    localparam int W = 32;

    localparam logic [6:0] ADD = 7'b0011000, SUB = 7'b0011001;
    localparam logic [6:0] XOR = 7'b0101111, OR_ = 7'b0101110;
    localparam logic [6:0] AND = 7'b0010101, SRA = 7'b0100100;
    localparam logic [6:0] SRL = 7'b0100101, SLL = 7'b0100111;
    localparam logic [6:0] LTS = 7'b0000000, LTU = 7'b0000001;
    localparam logic [6:0] SLTS = 7'b0000010, SLTU = 7'b0000011;
    localparam logic [6:0] LES = 7'b0000100, LEU = 7'b0000101;
    localparam logic [6:0] SLETS = 7'b0000110, SLETU = 7'b0000111;
    localparam logic [6:0] GTS = 7'b0001000, GTU = 7'b0001001;
    localparam logic [6:0] GES = 7'b0001010, GEU = 7'b0001011;
    localparam logic [6:0] EQ = 7'b0001100, NE = 7'b0001101;
    localparam logic [6:0] DIVU = 7'b0110000, DIV = 7'b0110001;
    localparam logic [6:0] REMU = 7'b0110010, REM = 7'b0110011;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable_i;
    logic [6:0]   operator_i;
    logic [W-1:0] operand_a_i;
    logic [W-1:0] operand_b_i;
    logic [1:0]   vector_mode_i;
    logic [W-1:0] result_o;
    logic         comparison_result_o;
    logic         ready_o;
    logic         ex_ready_i;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_alu_iter #(.WIDTH(W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable_i            (enable_i),
        .operator_i          (operator_i),
        .operand_a_i         (operand_a_i),
        .operand_b_i         (operand_b_i),
        .vector_mode_i       (vector_mode_i),
        .result_o            (result_o),
        .comparison_result_o (comparison_result_o),
        .ready_o             (ready_o),
        .ex_ready_i          (ex_ready_i)
    );

    typedef struct {
        logic [6:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   vm;
        logic [W-1:0] res;
        logic         cmp;
        bit           chk_cmp;
        string        name;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model of the single-cycle ops.
    function automatic void ref_alu(input logic [6:0] op,
                                    input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [1:0] vm,
                                    output logic [W-1:0] res, output logic cmp,
                                    output bit is_cmp);
        int     lw;
        bit     sg;
        bit     r;
        longint av, bv, one;
        one    = 1;
        res    = '0;
        cmp    = 1'b0;
        is_cmp = 1'b0;
        lw = (vm == 2'b11) ? 8 : (vm == 2'b10) ? 16 : W;
        sg = op inside {LTS, LES, GTS, GES, SLTS, SLETS};
        case (op)
            ADD: res = a + b;
            SUB: res = a - b;
            AND: res = a & b;
            OR_: res = a | b;
            XOR: res = a ^ b;
            SLL: res = a << b[4:0];
            SRL: res = a >> b[4:0];
            SRA: res = W'($signed(a) >>> b[4:0]);
            default: begin
                if (op inside {EQ, NE, GTS, GTU, GES, GEU, LTS, LTU, LES, LEU,
                               SLTS, SLTU, SLETS, SLETU}) begin
                    is_cmp = 1'b1;
                    for (int l = 0; l < W / lw; l++) begin
                        av = longint'(a >> (l * lw)) & ((one << lw) - 1);
                        bv = longint'(b >> (l * lw)) & ((one << lw) - 1);
                        if (sg && av >= (one << (lw - 1))) av = av - (one << lw);
                        if (sg && bv >= (one << (lw - 1))) bv = bv - (one << lw);
                        case (op)
                            EQ:                r = av == bv;
                            NE:                r = av != bv;
                            GTS, GTU:          r = av > bv;
                            GES, GEU:          r = av >= bv;
                            LTS, LTU, SLTS, SLTU: r = av < bv;
                            default:           r = av <= bv;
                        endcase
                        for (int k = 0; k < lw; k++) res[l * lw + k] = r;
                        cmp = r;
                    end
                    if (op inside {SLTS, SLTU, SLETS, SLETU}) res = {31'b0, cmp};
                end
            end
        endcase
    endfunction

    function automatic logic [W-1:0] ref_div(input logic [6:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint sa, sb, q, r;
        sa = op[0] ? longint'($signed(a)) : longint'({32'b0, a});
        sb = op[0] ? longint'($signed(b)) : longint'({32'b0, b});
        if (b == 0) begin
            q = -1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return op[1] ? r[W-1:0] : q[W-1:0];
    endfunction

    // Number of cycles ready_o stays low, counting the accept cycle.
    function automatic int ref_lat(input logic [6:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
`ifdef RISCV_ALU_DIV_EARLY_TERM_EN
        longint ma, mb;
        int     n;
        ma = op[0] ? longint'($signed(a)) : longint'({32'b0, a});
        mb = op[0] ? longint'($signed(b)) : longint'({32'b0, b});
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (mb == 0 || ma < mb) return 1;
        n = 0;
        while (n < 64 && (ma >> n) != 0) n++;
        return n + 1;
`else
        return W + 1;
`endif
    endfunction

    task automatic apply(input vec_t v);
        enable_i      = 1'b1;
        operator_i    = v.op;
        operand_a_i   = v.a;
        operand_b_i   = v.b;
        vector_mode_i = v.vm;
        #2;
        check({v.name, "_res"}, result_o, v.res);
        check({v.name, "_rdy"}, W'(ready_o), W'(1));
        if (v.chk_cmp) check({v.name, "_cmp"}, W'(comparison_result_o), W'(v.cmp));
    endtask

    // Starts at posedge+1 in IDLE; returns inside the first DONE cycle.
    task automatic run_div(input logic [6:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp,
                           input string name);
        int low;
        bit seen;
        enable_i      = 1'b1;
        operator_i    = op;
        operand_a_i   = a;
        operand_b_i   = b;
        vector_mode_i = 2'($urandom);
        #2;
        low  = ready_o ? 0 : 1;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            step();
            operator_i  = {5'b01100, 2'($urandom)};
            operand_a_i = $urandom;
            operand_b_i = $urandom;
            #2;
            if (ready_o) seen = 1'b1;
            else low++;
        end
        enable_i = 1'b0;
        check({name, "_done"}, W'(seen), W'(1));
        check_int({name, "_lat"}, low, ref_lat(op, a, b));
        check({name, "_res"}, result_o, exp);
    endtask

    vec_t         tbl[$];
    logic [6:0]   sc_ops[22];
    logic [W-1:0] er;
    logic         ec;
    bit           ic;
    vec_t         rv;

    initial begin
        sc_ops = '{ADD, SUB, XOR, OR_, AND, SRA, SRL, SLL, LTS, LTU, SLTS, SLTU,
                   LES, LEU, SLETS, SLETU, GTS, GTU, GES, GEU, EQ, NE};
        tbl.push_back('{ADD, 32'h7FFFFFFF, 32'h1, 2'b00, 32'h80000000, 1'b0, 0, "add_ovf"});
        tbl.push_back('{SUB, 32'd5, 32'd7, 2'b00, 32'hFFFFFFFE, 1'b0, 0, "sub_neg"});
        tbl.push_back('{GTS, 32'h80017F02, 32'h7F00FF01, 2'b11, 32'h00FFFFFF, 1'b0, 1, "v8_gts"});
        tbl.push_back('{AND, 32'hF0F0FFFF, 32'h0FF0F00F, 2'b00, 32'h00F0F00F, 1'b0, 0, "and"});
        tbl.push_back('{OR_, 32'h12340000, 32'h00005678, 2'b00, 32'h12345678, 1'b0, 0, "or"});
        tbl.push_back('{XOR, 32'hFFFF0000, 32'hF0F0F0F0, 2'b00, 32'h0F0FF0F0, 1'b0, 0, "xor"});
        tbl.push_back('{SLL, 32'h1, 32'h24, 2'b00, 32'h10, 1'b0, 0, "sll_mask"});
        tbl.push_back('{SRA, 32'h80000000, 32'd4, 2'b00, 32'hF8000000, 1'b0, 0, "sra"});
        tbl.push_back('{SRL, 32'h80000000, 32'd31, 2'b00, 32'h1, 1'b0, 0, "srl"});
        tbl.push_back('{EQ, 32'h12345678, 32'h12345678, 2'b00, 32'hFFFFFFFF, 1'b1, 1, "eq"});
        tbl.push_back('{LTU, 32'h1, 32'hFFFFFFFF, 2'b00, 32'hFFFFFFFF, 1'b1, 1, "ltu"});
        tbl.push_back('{LTS, 32'h1, 32'hFFFFFFFF, 2'b00, 32'h0, 1'b0, 1, "lts"});
        tbl.push_back('{SLTS, 32'hFFFFFFFF, 32'h1, 2'b00, 32'h1, 1'b1, 1, "slts"});
        tbl.push_back('{SLETU, 32'd5, 32'd5, 2'b00, 32'h1, 1'b1, 1, "sletu"});
        tbl.push_back('{LTS, 32'h80000001, 32'h00010000, 2'b10, 32'hFFFF0000, 1'b1, 1, "v16_lts"});
        tbl.push_back('{EQ, 32'h11223344, 32'h11FF3300, 2'b11, 32'hFF00FF00, 1'b1, 1, "v8_eq"});
        tbl.push_back('{GEU, 32'h0, 32'h1, 2'b00, 32'h0, 1'b0, 1, "geu"});
        tbl.push_back('{7'b1111111, 32'h5, 32'h6, 2'b00, 32'h0, 1'b0, 0, "unsupported"});

        rst_n         = 1'b0;
        enable_i      = 1'b0;
        operator_i    = LTS;
        operand_a_i   = '0;
        operand_b_i   = '0;
        vector_mode_i = 2'b00;
        ex_ready_i    = 1'b1;
        step();
        step();
        #2;
        check("reset_ready", W'(ready_o), W'(1));
        check("reset_result", result_o, '0);
        step();
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i]);
            step();
        end

        for (int n = 0; n < 300; n++) begin
            rv.op = sc_ops[$urandom_range(0, 21)];
            rv.a  = $urandom;
            rv.b  = ($urandom_range(0, 3) == 0) ? rv.a ^ (32'h1 << $urandom_range(0, 31))
                                                 : $urandom;
            if ($urandom_range(0, 3) == 0) rv.b = rv.a;
            rv.vm = 2'($urandom);
            ref_alu(rv.op, rv.a, rv.b, rv.vm, er, ec, ic);
            rv.res     = er;
            rv.cmp     = ec;
            rv.chk_cmp = ic;
            rv.name    = $sformatf("rnd_op%b_vm%b", rv.op, rv.vm);
            apply(rv);
            step();
        end

        run_div(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_m7_2");
        step();
        run_div(REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_m7_2");
        step();
        run_div(DIVU, 32'd100, 32'd7, 32'd14, "divu_100_7");
        step();
        run_div(DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_by0");
        step();
        run_div(REM, 32'd5, 32'd0, 32'd5, "rem_by0");
        step();
        run_div(DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, "div_neg_by0");
        step();
        run_div(REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, "rem_neg_by0");
        step();
        run_div(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        step();
        run_div(REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem_ovf");
        step();
        run_div(DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, "div_7_m2");
        step();
        run_div(DIVU, 32'd3, 32'd9, 32'd0, "divu_3_9");
        step();

        // Stall in DONE: result held while EX is not advancing.
        ex_ready_i = 1'b0;
        run_div(DIVU, 32'd1000, 32'd10, 32'd100, "hold_div");
        for (int h = 0; h < 4; h++) begin
            step();
            enable_i    = 1'b1;
            operator_i  = ADD;
            operand_a_i = $urandom;
            operand_b_i = $urandom;
            #2;
            check($sformatf("hold_rdy%0d", h), W'(ready_o), W'(1));
            check($sformatf("hold_res%0d", h), result_o, 32'd100);
        end
        step();
        ex_ready_i = 1'b1;
        enable_i   = 1'b0;
        #2;
        check("release_res", result_o, 32'd100);
        step();
        run_div(DIVU, 32'd81, 32'd9, 32'd9, "b2b_div");
        step();

        // Reset at RUN iteration 10.
        enable_i    = 1'b1;
        operator_i  = DIVU;
        operand_a_i = 32'hFFFFFFFF;
        operand_b_i = 32'd3;
        for (int s = 0; s < 10; s++) begin
            step();
            enable_i = 1'b0;
        end
        rst_n = 1'b0;
        step();
        rst_n       = 1'b1;
        enable_i    = 1'b1;
        operator_i  = ADD;
        operand_a_i = 32'd3;
        operand_b_i = 32'd4;
        #2;
        check("rst_run_rdy", W'(ready_o), W'(1));
        check("rst_run_res", result_o, 32'd7);
        step();
        run_div(DIVU, 32'hFFFFFFFF, 32'd3, 32'h55555555, "post_rst_div");

        // Reset while holding in DONE.
        ex_ready_i = 1'b0;
        rst_n      = 1'b0;
        step();
        rst_n       = 1'b1;
        ex_ready_i  = 1'b1;
        enable_i    = 1'b1;
        operator_i  = ADD;
        operand_a_i = 32'd1;
        operand_b_i = 32'd1;
        #2;
        check("rst_done_rdy", W'(ready_o), W'(1));
        check("rst_done_res", result_o, 32'd2);
        step();

        for (int n = 0; n < 30; n++) begin
            logic [6:0]   op;
            logic [W-1:0] a, b;
            op = {5'b01100, 2'($urandom)};
            a  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_div(op, a, b, ref_div(op, a, b), $sformatf("rdiv%0d", n));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_alu_iter.md
Name: riscv_alu_iter

Overview:
- Parametrised-width integer ALU for the RISC-V EX stage.
- Single-cycle logic, add/sub, shift and lane-wise compare operations, as before.
- Adds iterative multi-cycle signed and unsigned divide and remainder, using a restoring algorithm at one quotient bit per cycle.
- Stalls the pipeline through the ready_o / ex_ready_i handshake.

Parameters:
- WIDTH, 32, datapath width; multiple of 8, minimum 16.
- LANES, WIDTH/8, number of byte lanes for VEC_MODE8 compares; VEC_MODE16 uses LANES/2 halfword lanes.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- enable_i  in  1  operator/operands valid this cycle.
- operator_i  in  7  ALU opcode (existing ALU_* encodings).
- operand_a_i  in  WIDTH  operand A / dividend.
- operand_b_i  in  WIDTH  operand B / divisor / shift amount.
- vector_mode_i  in  2  2'b10 = 16-bit lanes, 2'b11 = 8-bit lanes, else scalar.
- result_o  out  WIDTH  result.
- comparison_result_o  out  1  MSB-lane compare result (branch decision).
- ready_o  out  1  1 = result valid / ALU can accept.
- ex_ready_i  in  1  EX stage advances this cycle.

Behaviour:
- Clocking and reset: one clock (clk); rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Single-cycle ops (AND, OR, XOR, ADD, SUB, SLL, SRL, SRA, EQ/NE/GT*/GE*/LT*/LE*, SLT*/SLET*):
  - Combinational, ready_o=1 in the same cycle.
  - Shift amount is operand_b_i[$clog2(WIDTH)-1:0].
- Compares:
  - Computed per byte lane, then merged per vector mode.
  - Signedness applies to the top byte of each active lane only.
  - Vector compares replicate each lane result across its lane bits.
  - SLT*/SLET* return {0…, comparison_result_o}.
- Divide opcodes: DIVU 7'b0110000, DIV 7'b0110001, REMU 7'b0110010, REM 7'b0110011; scalar only (vector_mode_i ignored).
- FSM states IDLE, RUN, DONE; reset → IDLE, counter=0, quotient/remainder regs=0.
- IDLE:
  - On enable_i & div opcode: ready_o=0 combinationally in that cycle.
  - Latch operator, signs and magnitudes of A and B; counter=WIDTH; → RUN.
- RUN:
  - Each cycle, shift one dividend bit into the partial remainder, conditional subtract, counter-1.
  - Counter reaching 0 → DONE.
  - ready_o=0 throughout.
  - Input changes are ignored; only operands latched in IDLE are used.
- DONE:
  - result_o = sign-corrected quotient or remainder (registered); ready_o=1.
  - ex_ready_i=1 → IDLE next cycle; otherwise hold DONE and result stable.
- Latency: accept in cycle t, RUN cycles t+1..t+WIDTH, ready_o=1 at t+WIDTH+1.
- Sign rules:
  - Quotient negated iff signs of A and B differ (signed ops).
  - Remainder takes the sign of A.
- Division by zero: quotient = all ones; remainder = A. Same latency as a normal divide.
- Overflow: DIV of MIN by -1 → quotient = MIN, remainder 0 (falls out of magnitude arithmetic; no special path).
- Non-div opcode while in DONE with ex_ready_i=0: still shows the div result; the pipeline is stalled, so this cannot be a new instruction.
- Reset asserted mid-RUN or in DONE: next cycle IDLE, ready_o=1, registers cleared. No partial result is emitted.
- Unsupported opcode: result_o = 0, ready_o=1. Simulation-only warning.

Optional Feature:
- Macro: RISCV_ALU_DIV_EARLY_TERM_EN.
- Defined, in IDLE on accept:
  - If divisor==0 or |A| < |B| (unsigned magnitudes): skip RUN, go directly to DONE next cycle (latency 1 stall cycle). Results as specified above.
  - Otherwise, counter is preloaded with WIDTH - clz(|A|), and the partial remainder is pre-shifted by clz(|A|).
- Undefined: fixed WIDTH-cycle RUN for every divide.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF+1 → result 0x80000000, ready_o=1 same cycle; SUB 5-7 → 0xFFFFFFFE.
- VEC_MODE8 GTS A=0x80017F02, B=0x7F00FF01 → result 0x00FFFFFF, comparison_result_o=0.
- DIV -7/2 → ready_o low 33 cycles, then result 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
- DONE with ex_ready_i=0 for 4 cycles → result held, ready_o=1; then ex_ready_i=1 → IDLE; a back-to-back divide is accepted the following cycle.
- rst_n low at RUN iteration 10 → next cycle ready_o=1, FSM IDLE. With RISCV_ALU_DIV_EARLY_TERM_EN: DIVU 3/9 → result 0 after 1 stall cycle.
